// File: rtl/memory_write_sequencer.sv
// Purpose: serialise one RISC-V store (SB/SH/SW) into little-endian single-byte writes on a byte-wide RAM port.
// Latency: start at edge 0 -> bytes in cycles 1..n -> done in cycle n+1 -> ready in cycle n+2; a reject pulses error in cycle 1.
// Backpressure: ready is high only in IDLE; start while busy is dropped, never queued.
module memory_write_sequencer #(
    parameter int depth = 512
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic        done,
    output logic        error,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_write_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [32:0] MEM_BYTES = 33'(depth) * 33'd4;

    state_t      state;
    logic [31:0] base_q;
    logic [31:0] data_q;
    logic [2:0]  len_q;
    logic [2:0]  idx_q;

    logic [2:0]  req_len;
    logic        bad_code;
    logic        misaligned;
    logic        out_of_range;
    logic        req_reject;
    logic [32:0] req_last;

    // Request decode; the range check is 33-bit so a base near 2^32 cannot wrap into range.
    always_comb begin
        req_len  = 3'd1;
        bad_code = 1'b0;
        case (funct3)
            3'b000:  req_len = 3'd1;
            3'b001:  req_len = 3'd2;
            3'b010:  req_len = 3'd4;
            default: bad_code = 1'b1;
        endcase
        misaligned   = ((funct3 == 3'b001) && address[0]) ||
                       ((funct3 == 3'b010) && (address[1:0] != 2'b00));
        req_last     = {1'b0, address} + {30'd0, req_len} - 33'd1;
        out_of_range = (req_last >= MEM_BYTES);
        req_reject   = bad_code | misaligned | out_of_range;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            base_q           <= 32'd0;
            data_q           <= 32'd0;
            len_q            <= 3'd0;
            idx_q            <= 3'd0;
            ready            <= 1'b1;
            done             <= 1'b0;
            error            <= 1'b0;
            mem_address      <= 32'd0;
            mem_data         <= 8'd0;
            mem_write_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done             <= 1'b0;
                    error            <= 1'b0;
                    mem_write_enable <= 1'b0;
                    mem_address      <= 32'd0;
                    mem_data         <= 8'd0;
                    ready            <= 1'b1;
                    if (start) begin
                        base_q <= address;
                        data_q <= write_data;
                        len_q  <= req_len;
                        ready  <= 1'b0;
                        if (req_reject) begin
                            state <= ERROR;
                            error <= 1'b1;
                            idx_q <= 3'd0;
                        end else begin
                            // Byte 0 goes out straight from the request so it lands in cycle 1.
                            state            <= WRITE;
                            mem_write_enable <= 1'b1;
                            mem_address      <= address;
                            mem_data         <= write_data[7:0];
                            idx_q            <= 3'd1;
                        end
                    end
                end

                WRITE: begin
                    ready <= 1'b0;
                    if (idx_q == len_q) begin
                        state            <= DONE;
                        done             <= 1'b1;
                        mem_write_enable <= 1'b0;
                        mem_address      <= 32'd0;
                        mem_data         <= 8'd0;
                        idx_q            <= 3'd0;
                    end else begin
                        mem_write_enable <= 1'b1;
                        mem_address      <= base_q + {29'd0, idx_q};
                        mem_data         <= data_q[{idx_q[1:0], 3'b000} +: 8];
                        idx_q            <= idx_q + 3'd1;
                    end
                end

                DONE: begin
                    state            <= IDLE;
                    done             <= 1'b0;
                    error            <= 1'b0;
                    ready            <= 1'b1;
                    mem_write_enable <= 1'b0;
                    mem_address      <= 32'd0;
                    mem_data         <= 8'd0;
                end

                ERROR: begin
                    state            <= IDLE;
                    done             <= 1'b0;
                    error            <= 1'b0;
                    ready            <= 1'b1;
                    mem_write_enable <= 1'b0;
                    mem_address      <= 32'd0;
                    mem_data         <= 8'd0;
                end

                default: begin
                    state            <= IDLE;
                    done             <= 1'b0;
                    error            <= 1'b0;
                    ready            <= 1'b1;
                    mem_write_enable <= 1'b0;
                    mem_address      <= 32'd0;
                    mem_data         <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_write_sequencer.sv
// Directed bench for memory_write_sequencer: cycle-exact checks of writes, done/error pulses, reset abort and ignored strobes.
module tb_memory_write_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;
    logic        done;
    logic        error;
    logic [31:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_write_enable;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    int wr_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [7:0] mem [logic [31:0]];

    memory_write_sequencer #(.depth(512)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .funct3           (funct3),
        .address          (address),
        .write_data       (write_data),
        .ready            (ready),
        .done             (done),
        .error            (error),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .mem_write_enable (mem_write_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte RAM model: captures whatever is presented at each rising edge.
    always @(posedge clock) begin
        if (mem_write_enable === 1'b1) begin
            wr_cnt++;
            mem[mem_address] = mem_data;
        end
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request for exactly one edge (edge 0), then scramble the inputs.
    task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] dat);
        start      = 1'b1;
        funct3     = f3;
        address    = addr;
        write_data = dat;
        step();
        start      = 1'b0;
        funct3     = 3'b111;
        address    = 32'hFFFF_0000;
        write_data = 32'h0000_0000;
    endtask

    task automatic expect_reject(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        int w0;
        w0 = wr_cnt;
        issue(f3, addr, 32'h5555_AAAA);
        check({tag, " c1 error"}, 32'(error), 32'd1);
        check({tag, " c1 we"},    32'(mem_write_enable), 32'd0);
        check({tag, " c1 ready"}, 32'(ready), 32'd0);
        check({tag, " c1 done"},  32'(done), 32'd0);
        step();
        check({tag, " c2 error"}, 32'(error), 32'd0);
        check({tag, " c2 ready"}, 32'(ready), 32'd1);
        check({tag, " c2 we"},    32'(mem_write_enable), 32'd0);
        check({tag, " writes"},   32'(wr_cnt - w0), 32'd0);
    endtask

    initial begin
        int w0;
        int d0;
        logic [31:0] exp_addr [4];
        logic [7:0]  exp_byte [4];

        reset_n    = 1'b0;
        start      = 1'b0;
        funct3     = 3'b000;
        address    = 32'd0;
        write_data = 32'd0;
        #12;
        check("rst ready", 32'(ready), 32'd1);
        check("rst done",  32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst we",    32'(mem_write_enable), 32'd0);
        check("rst addr",  mem_address, 32'd0);
        check("rst data",  32'(mem_data), 32'd0);
        reset_n = 1'b1;
        step();
        step();

        // SW 0xDEADBEEF at 0x10
        w0 = wr_cnt;
        exp_addr = '{32'h10, 32'h11, 32'h12, 32'h13};
        exp_byte = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        issue(3'b010, 32'h10, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sw c%0d we", i + 1),    32'(mem_write_enable), 32'd1);
            check($sformatf("sw c%0d addr", i + 1),  mem_address, exp_addr[i]);
            check($sformatf("sw c%0d data", i + 1),  32'(mem_data), 32'(exp_byte[i]));
            check($sformatf("sw c%0d ready", i + 1), 32'(ready), 32'd0);
            check($sformatf("sw c%0d done", i + 1),  32'(done), 32'd0);
            step();
        end
        check("sw c5 done",  32'(done), 32'd1);
        check("sw c5 we",    32'(mem_write_enable), 32'd0);
        check("sw c5 addr",  mem_address, 32'd0);
        check("sw c5 data",  32'(mem_data), 32'd0);
        check("sw c5 ready", 32'(ready), 32'd0);
        step();
        check("sw c6 done",  32'(done), 32'd0);
        check("sw c6 ready", 32'(ready), 32'd1);
        check("sw writes",   32'(wr_cnt - w0), 32'd4);
        check("sw mem 0x13", 32'(mem[32'h13]), 32'h0000_00DE);
        check("sw mem 0x10", 32'(mem[32'h10]), 32'h0000_00EF);

        // SB at the last legal byte
        w0 = wr_cnt;
        issue(3'b000, 32'h7FF, 32'h0000_00A5);
        check("sb c1 we",    32'(mem_write_enable), 32'd1);
        check("sb c1 addr",  mem_address, 32'h7FF);
        check("sb c1 data",  32'(mem_data), 32'h0000_00A5);
        step();
        check("sb c2 done",  32'(done), 32'd1);
        check("sb c2 we",    32'(mem_write_enable), 32'd0);
        step();
        check("sb c3 ready", 32'(ready), 32'd1);
        check("sb writes",   32'(wr_cnt - w0), 32'd1);

        expect_reject("sh misaligned", 3'b001, 32'h21);

        // SW ending exactly on the last legal byte
        w0 = wr_cnt;
        issue(3'b010, 32'h7FC, 32'h0403_0201);
        check("sw7fc c1 addr", mem_address, 32'h7FC);
        check("sw7fc c1 data", 32'(mem_data), 32'h0000_0001);
        step();
        step();
        step();
        check("sw7fc c4 addr", mem_address, 32'h7FF);
        check("sw7fc c4 data", 32'(mem_data), 32'h0000_0004);
        step();
        check("sw7fc c5 done", 32'(done), 32'd1);
        check("sw7fc error",   32'(error), 32'd0);
        step();
        check("sw7fc writes",  32'(wr_cnt - w0), 32'd4);

        expect_reject("sw 0x800",   3'b010, 32'h800);
        expect_reject("sw top",     3'b010, 32'hFFFF_FFFC);
        expect_reject("funct3 011", 3'b011, 32'h40);
        expect_reject("sh 0x800",   3'b001, 32'h7FF);

        // SH ending on the last legal byte
        w0 = wr_cnt;
        issue(3'b001, 32'h7FE, 32'h0000_1234);
        check("sh7fe c1 data", 32'(mem_data), 32'h0000_0034);
        step();
        check("sh7fe c2 addr", mem_address, 32'h7FF);
        check("sh7fe c2 data", 32'(mem_data), 32'h0000_0012);
        step();
        check("sh7fe c3 done", 32'(done), 32'd1);
        step();
        check("sh7fe writes",  32'(wr_cnt - w0), 32'd2);

        // Asynchronous reset in the middle of an SW
        w0 = wr_cnt;
        issue(3'b010, 32'h40, 32'h1122_3344);
        check("abort c1 addr", mem_address, 32'h40);
        step();
        check("abort c2 we",   32'(mem_write_enable), 32'd1);
        check("abort c2 addr", mem_address, 32'h41);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort async we",    32'(mem_write_enable), 32'd0);
        check("abort async addr",  mem_address, 32'd0);
        check("abort async ready", 32'(ready), 32'd1);
        #2;
        reset_n = 1'b1;
        step();
        step();
        step();
        check("abort post ready", 32'(ready), 32'd1);
        check("abort post we",    32'(mem_write_enable), 32'd0);
        check("abort writes",     32'(wr_cnt - w0), 32'd1);

        // Second strobe during WRITE and DONE must be ignored
        w0 = wr_cnt;
        d0 = done_cnt;
        issue(3'b000, 32'h50, 32'h0000_005A);
        start      = 1'b1;
        funct3     = 3'b010;
        address    = 32'h60;
        write_data = 32'hCAFE_BABE;
        check("ign c1 addr", mem_address, 32'h50);
        check("ign c1 data", 32'(mem_data), 32'h0000_005A);
        step();
        check("ign c2 done", 32'(done), 32'd1);
        check("ign c2 we",   32'(mem_write_enable), 32'd0);
        step();
        start = 1'b0;
        check("ign c3 ready", 32'(ready), 32'd1);
        check("ign c3 we",    32'(mem_write_enable), 32'd0);
        step();
        step();
        step();
        check("ign writes",     32'(wr_cnt - w0), 32'd1);
        check("ign done count", 32'(done_cnt - d0), 32'd1);
        check("ign mem 0x50",   32'(mem[32'h50]), 32'h0000_005A);
        check("done+error overlap", 32'(both_cnt), 32'd0);
        check("error pulse count",  32'(err_cnt), 32'd5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
